// File: rtl/matrix_glyph_streamer_if.sv
// Host-side bundle for matrix_glyph_streamer: frame control, glyph RAM write port,
// colours, and the APA102 strip outputs with status.
interface matrix_glyph_streamer_if #(
    parameter int MATRIX_W   = 8,
    parameter int MATRIX_H   = 8,
    parameter int NUM_GLYPHS = 16
);
    localparam int N     = MATRIX_W * MATRIX_H;
    localparam int IDX_W = $clog2(NUM_GLYPHS);

    logic             start;
    logic             auto_run;
    logic             glyph_we;
    logic [IDX_W-1:0] glyph_waddr;
    logic [N-1:0]     glyph_wdata;
    logic [IDX_W:0]   glyph_count;
    logic [23:0]      fg_rgb;
    logic [23:0]      bg_rgb;
    logic [4:0]       brightness;
    logic             sclk;
    logic             sdo;
    logic             busy;
    logic             frame_done;
    logic [IDX_W-1:0] glyph_idx;

    modport master (
        output start, auto_run, glyph_we, glyph_waddr, glyph_wdata, glyph_count,
               fg_rgb, bg_rgb, brightness,
        input  sclk, sdo, busy, frame_done, glyph_idx
    );

    modport slave (
        input  start, auto_run, glyph_we, glyph_waddr, glyph_wdata, glyph_count,
               fg_rgb, bg_rgb, brightness,
        output sclk, sdo, busy, frame_done, glyph_idx
    );
endinterface

// File: rtl/matrix_glyph_streamer.sv
// Streams a monochrome glyph bitmap to an APA102 LED matrix as one serial frame,
// stepping through a sequence of glyphs held in an internal glyph RAM.
module matrix_glyph_streamer #(
    parameter int MATRIX_W    = 8,
    parameter int MATRIX_H    = 8,
    parameter int NUM_GLYPHS  = 16,
    parameter int CLK_DIV     = 1,
    parameter int SERPENTINE  = 1,
    parameter int HOLD_FRAMES = 1,
    parameter int END_BITS    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_glyph_streamer_if.slave bus
);
    localparam int N        = MATRIX_W * MATRIX_H;
    localparam int IDX_W    = $clog2(NUM_GLYPHS);
    localparam int PIX_BITS = N * 32;
    localparam int MAX_BITS = (PIX_BITS > END_BITS) ? PIX_BITS : END_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam int DIV_W    = $clog2(CLK_DIV + 1);
    localparam int HOLD_W   = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, START_FR, PIXELS, END_FR, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic [HOLD_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [IDX_W-1:0] glyph_idx_q, glyph_idx_d;
    logic [N-1:0]     glyph_sh_q, glyph_sh_d;
    logic [23:0]      fg_q, fg_d, bg_q, bg_d;
    logic [4:0]       bri_q, bri_d;
    logic [N-1:0]     glyph_ram [NUM_GLYPHS];

    logic             half_tick;
    logic             last_cycle_next;
    logic [IDX_W:0]   eff_count;
    logic [IDX_W:0]   idx_inc;

    // Bit value at position cnt of a streaming state, taken from the shadow registers.
    function automatic logic stream_bit(input state_t st, input logic [CNT_W-1:0] cnt,
                                        input logic [N-1:0] glyph, input logic [23:0] fg,
                                        input logic [23:0] bg, input logic [4:0] bri);
        int          k, r, c;
        logic [23:0] rgb;
        logic [31:0] word;
        stream_bit = (st == END_FR);
        if (st == PIXELS) begin
            k = int'(cnt) / 32;
            r = k / MATRIX_W;
            c = k % MATRIX_W;
            if (SERPENTINE != 0 && r[0]) c = MATRIX_W - 1 - c;
            rgb  = glyph[N - 1 - (r * MATRIX_W + c)] ? fg : bg;
            word = {3'b111, bri, rgb[7:0], rgb[15:8], rgb[23:16]};
            stream_bit = word[31 - (int'(cnt) % 32)];
        end
    endfunction

    assign half_tick = (int'(div_cnt_q) == CLK_DIV - 1);
    // The final clk of the last end bit is spent in DONE with sclk still high.
    assign last_cycle_next = (sclk_q && int'(div_cnt_q) == CLK_DIV - 2) ||
                             (!sclk_q && half_tick && CLK_DIV == 1);

    always_comb begin
        eff_count = bus.glyph_count;
        if (bus.glyph_count == '0) eff_count = (IDX_W+1)'(1);
        else if (bus.glyph_count > (IDX_W+1)'(NUM_GLYPHS)) eff_count = (IDX_W+1)'(NUM_GLYPHS);
        idx_inc = {1'b0, glyph_idx_q} + (IDX_W+1)'(1);
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        sclk_d      = sclk_q;
        sdo_d       = sdo_q;
        frame_cnt_d = frame_cnt_q;
        glyph_idx_d = glyph_idx_q;
        glyph_sh_d  = glyph_sh_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        bri_d       = bri_q;
        case (state_q)
            IDLE: begin
                sclk_d    = 1'b0;
                sdo_d     = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (bus.start || bus.auto_run) begin
                    state_d    = START_FR;
                    glyph_sh_d = glyph_ram[glyph_idx_q];
                    fg_d       = bus.fg_rgb;
                    bg_d       = bus.bg_rgb;
                    bri_d      = bus.brightness;
                end
            end
            START_FR, PIXELS, END_FR: begin
                div_cnt_d = half_tick ? '0 : div_cnt_q + 1'b1;
                if (half_tick && !sclk_q) begin
                    sclk_d = 1'b1;
                end else if (half_tick) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (state_q == START_FR && bit_cnt_q == CNT_W'(31)) begin
                        state_d   = PIXELS;
                        bit_cnt_d = '0;
                    end else if (state_q == PIXELS && bit_cnt_q == CNT_W'(PIX_BITS - 1)) begin
                        state_d   = END_FR;
                        bit_cnt_d = '0;
                    end
                    sdo_d = stream_bit(state_d, bit_cnt_d, glyph_sh_q, fg_q, bg_q, bri_q);
                end
                if (state_q == END_FR && bit_cnt_q == CNT_W'(END_BITS - 1) && last_cycle_next) begin
                    state_d   = DONE;
                    sclk_d    = 1'b1;
                    div_cnt_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                sdo_d   = 1'b0;
                if (frame_cnt_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                    frame_cnt_d = '0;
                    glyph_idx_d = (idx_inc >= eff_count) ? '0 : idx_inc[IDX_W-1:0];
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: flops take <= so every register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            frame_cnt_q <= '0;
            glyph_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            sclk_q      <= sclk_d;
            sdo_q       <= sdo_d;
            frame_cnt_q <= frame_cnt_d;
            glyph_idx_q <= glyph_idx_d;
        end
    end

    // Shadows are always reloaded before use, so they need no reset.
    always_ff @(posedge clk) begin
        glyph_sh_q <= glyph_sh_d;
        fg_q       <= fg_d;
        bg_q       <= bg_d;
        bri_q      <= bri_d;
    end

    // NOTE: the glyph RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && bus.glyph_we) glyph_ram[bus.glyph_waddr] <= bus.glyph_wdata;
    end

    assign bus.sclk       = sclk_q;
    assign bus.sdo        = sdo_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = (state_q == DONE);
    assign bus.glyph_idx  = glyph_idx_q;
endmodule
